// File: rtl/ks_prefix_pipe_32b_pkg.sv
// ---------------------------------------------------------------------------
// ks_prefix_pipe_32b_pkg
// Shared definitions for the 32-bit Kogge-Stone prefix pipeline:
//   KS_W       datapath width
//   KS_LEVELS  number of prefix levels (span 1, 2, 4, 8, 16)
//   ks_pg_t    {P, G} group propagate/generate bundle carried between stages
//   ks_span()  span of a prefix level, 1 << level
// ---------------------------------------------------------------------------
package ks_prefix_pipe_32b_pkg;

   localparam int unsigned KS_W      = 32;
   localparam int unsigned KS_LEVELS = 5;

   typedef struct packed {
      logic [KS_W-1:0] p;
      logic [KS_W-1:0] g;
   } ks_pg_t;

   function automatic int unsigned ks_span(input int unsigned level);
      return 32'd1 << level;
   endfunction

endpackage

// File: rtl/ks_level_32b.sv
// ---------------------------------------------------------------------------
// ks_level_32b
// One combinational row of Kogge-Stone black/grey cells.
//   SPAN   distance to the combining bit for this level
//   pg_i   incoming group {P, G}
//   pg_o   outgoing group {P', G'}; bits below SPAN pass through unchanged
// ---------------------------------------------------------------------------
module ks_level_32b
   import ks_prefix_pipe_32b_pkg::*;
#(
   parameter int unsigned SPAN = 1
) (
   input  ks_pg_t pg_i,
   output ks_pg_t pg_o
);

   logic [KS_W-1:0] p_s;
   logic [KS_W-1:0] g_s;

   for (genvar i = 0; i < KS_W; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
         assign g_s[i] = pg_i.g[i] | (pg_i.p[i] & pg_i.g[i-SPAN]);
         assign p_s[i] = pg_i.p[i] & pg_i.p[i-SPAN];
      end else begin : g_pass
         assign g_s[i] = pg_i.g[i];
         assign p_s[i] = pg_i.p[i];
      end
   end

   assign pg_o = '{p: p_s, g: g_s};

endmodule

// File: rtl/ks_prefix_pipe_32b.sv
// ---------------------------------------------------------------------------
// ks_prefix_pipe_32b
// Six-stage pipelined Kogge-Stone carry network plus sum stage.
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_valid / o_ready  input handshake; o_ready is the global enable
//   i_pk_1, i_gk_1     bitwise propagate / generate from the PG stage
//   i_c0_1             carry-in
//   o_valid / i_ready  output handshake
//   o_sum, o_cout      registered sum and carry-out
// S1 captures inputs with carry-in folded into G[0]; S2..S5 register the
// span 1..8 levels; the span-16 level feeds the sum XOR registered in S6.
// ---------------------------------------------------------------------------
module ks_prefix_pipe_32b
   import ks_prefix_pipe_32b_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [KS_W-1:0] i_pk_1,
   input  logic [KS_W-1:0] i_gk_1,
   input  logic            i_c0_1,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [KS_W-1:0] o_sum,
   output logic            o_cout
);

   logic            en_s;
   ks_pg_t          pg1_d;
   ks_pg_t          pg_q   [1:KS_LEVELS];
   ks_pg_t          lvl_s  [1:KS_LEVELS];
   logic [KS_W-1:0] praw_q [1:KS_LEVELS];
   logic [KS_LEVELS:1] c0_q;
   logic [KS_LEVELS+1:1] vld_q;
   logic [KS_W-1:0] sum_d;
   logic [KS_W-1:0] sum_q;
   logic            cout_d;
   logic            cout_q;
   logic [KS_W-1:0] unused_p5_s;

   // Whole-pipe stall: everything moves when the output slot is free or drains.
   assign en_s    = ~vld_q[KS_LEVELS+1] | i_ready;
   assign o_ready = en_s;
   assign o_valid = vld_q[KS_LEVELS+1];
   assign o_sum   = sum_q;
   assign o_cout  = cout_q;

   // Level k combines the bundle held in stage k; level 5 feeds the sum.
   for (genvar k = 1; k <= KS_LEVELS; k++) begin : g_lvl
      ks_level_32b #(.SPAN(ks_span(k - 1))) u_lvl (
         .pg_i (pg_q[k]),
         .pg_o (lvl_s[k])
      );
   end

   // Final group propagate is not needed once all carries are resolved.
   assign unused_p5_s = lvl_s[KS_LEVELS].p;

   // Stage-1 bundle and sum stage next-state.
   always_comb begin
      pg1_d.p = {i_pk_1[KS_W-1:1], 1'b0};
      pg1_d.g = {i_gk_1[KS_W-1:1], i_gk_1[0] | (i_pk_1[0] & i_c0_1)};
      // G5[i-1] is the carry into bit i; c0 is the carry into bit 0.
      sum_d   = praw_q[KS_LEVELS] ^ {lvl_s[KS_LEVELS].g[KS_W-2:0], c0_q[KS_LEVELS]};
      cout_d  = lvl_s[KS_LEVELS].g[KS_W-1];
   end

   // Pipeline registers: clear on reset, advance together on enable, else hold.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q  <= 6'd0;
         c0_q   <= 5'd0;
         sum_q  <= 32'd0;
         cout_q <= 1'b0;
         for (int k = 1; k <= KS_LEVELS; k++) begin
            pg_q[k]   <= '{p: 32'd0, g: 32'd0};
            praw_q[k] <= 32'd0;
         end
      end else if (en_s) begin
         vld_q     <= {vld_q[KS_LEVELS:1], i_valid};
         pg_q[1]   <= pg1_d;
         praw_q[1] <= i_pk_1;
         c0_q[1]   <= i_c0_1;
         for (int k = 2; k <= KS_LEVELS; k++) begin
            pg_q[k]   <= lvl_s[k-1];
            praw_q[k] <= praw_q[k-1];
            c0_q[k]   <= c0_q[k-1];
         end
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

endmodule

// File: tb/tb_ks_prefix_pipe_32b.sv
module tb_ks_prefix_pipe_32b;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv;
   logic        ordy;
   logic [31:0] pk;
   logic [31:0] gk;
   logic        c0;
   logic        ov;
   logic        ir;
   logic [31:0] sum;
   logic        cout;

   always #5 clk = ~clk;

   ks_prefix_pipe_32b dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (iv),
      .o_ready (ordy),
      .i_pk_1  (pk),
      .i_gk_1  (gk),
      .i_c0_1  (c0),
      .o_valid (ov),
      .i_ready (ir),
      .o_sum   (sum),
      .o_cout  (cout)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] a_v, b_v;
   logic        c0_v;
   logic [32:0] exp_q[$];

   logic        ov_s, or_s, oc_s, ir_s, ain_s, aout_s;
   logic [31:0] os_s;

   // Reference: plain 33-bit addition of the original operands.
   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin);
      return {1'b0, a} + {1'b0, b} + {32'd0, cin};
   endfunction

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic cin);
      a_v = a; b_v = b; c0_v = cin;
      iv = v; pk = a ^ b; gk = a & b; c0 = cin;
   endtask

   // One cycle: sample at negedge, record accepted operand in the model, clock.
   task automatic step;
      @(negedge clk);
      ov_s = ov; os_s = sum; oc_s = cout; or_s = ordy; ir_s = ir;
      ain_s  = iv & ordy & ~rst;
      aout_s = ov & ir;
      if (ain_s) exp_q.push_back(ref_add(a_v, b_v, c0_v));
      @(posedge clk);
      #1;
      if (rst) exp_q.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1; ir = 1'b0;
      drive(1'b1, 32'h1234_0000, 32'h0000_5678, 1'b1);
      step();
      step();
      rst = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      step();
      n_checks++; if (ov_s !== 1'b0) $display("FAIL reset_valid: got %b want 0", ov_s); else n_pass++;
      n_checks++; if (os_s !== 32'd0) $display("FAIL reset_sum: got %h want 0", os_s); else n_pass++;
      n_checks++; if (oc_s !== 1'b0) $display("FAIL reset_cout: got %b want 0", oc_s); else n_pass++;
      n_checks++; if (or_s !== 1'b1) $display("FAIL reset_ready: got %b want 1", or_s); else n_pass++;
      ir = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++;
         if (ov_s !== 1'b0) $display("FAIL reset_dropped: cycle %0d o_valid %b want 0", i, ov_s);
         else n_pass++;
      end
   endtask

   task automatic test_directed;
      logic [31:0] ta [4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF};
      logic [31:0] tb [4] = '{32'h0000_0001, 32'h0FED_CBA8, 32'h0FED_CBA8, 32'h0000_0000};
      logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [32:0] te [4] = '{33'h1_0000_0000, 33'h0_2222_2221, 33'h0_2222_2220, 33'h1_0000_0000};
      int cnt;
      ir = 1'b1;
      for (int t = 0; t < 4; t++) begin
         drive(1'b1, ta[t], tb[t], tc[t]);
         step();
         n_checks++; if (ain_s !== 1'b1) $display("FAIL dir_accept%0d: got %b want 1", t, ain_s); else n_pass++;
         drive(1'b0, 32'd0, 32'd0, 1'b0);
         cnt = 0;
         do begin
            step();
            cnt++;
         end while (!ov_s && cnt < 20);
         n_checks++; if (cnt != 6) $display("FAIL dir_latency%0d: got %0d want 6", t, cnt); else n_pass++;
         n_checks++;
         if ({oc_s, os_s} !== te[t]) $display("FAIL dir_value%0d: got %h want %h", t, {oc_s, os_s}, te[t]);
         else n_pass++;
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back;
      logic [32:0] e;
      logic [31:0] a;
      int n_out = 0;
      int guard = 0;
      ir = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         if (i % 50 == 7) drive(1'b1, a, ~a, 1'b1);
         else drive(1'b1, a, $urandom, $urandom_range(1, 0) == 1);
         step();
         if (aout_s) begin
            n_out++;
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL b2b_extra: got %h want none", {oc_s, os_s});
            else begin
               e = exp_q.pop_front();
               if ({oc_s, os_s} !== e) $display("FAIL b2b_value: got %h want %h", {oc_s, os_s}, e);
               else n_pass++;
            end
         end
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      while (exp_q.size() > 0 && guard < 20) begin
         step();
         guard++;
         if (aout_s) begin
            n_out++;
            e = exp_q.pop_front();
            n_checks++;
            if ({oc_s, os_s} !== e) $display("FAIL b2b_value: got %h want %h", {oc_s, os_s}, e);
            else n_pass++;
         end
      end
      n_checks++; if (n_out != 1000) $display("FAIL b2b_count: got %0d want 1000", n_out); else n_pass++;
   endtask

   task automatic test_random_stall;
      logic [32:0] e;
      logic [32:0] prev = 33'd0;
      logic        hold = 1'b0;
      int guard = 0;
      for (int i = 0; i < 600; i++) begin
         ir = ($urandom_range(1, 0) == 1);
         drive($urandom_range(3, 0) != 0, $urandom, $urandom, $urandom_range(1, 0) == 1);
         step();
         if (hold) begin
            n_checks++;
            if (ov_s !== 1'b1 || {oc_s, os_s} !== prev)
               $display("FAIL stall_hold: got v=%b %h want v=1 %h", ov_s, {oc_s, os_s}, prev);
            else n_pass++;
         end
         hold = ov_s & ~ir_s;
         prev = {oc_s, os_s};
         if (aout_s) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL stall_extra: got %h want none", {oc_s, os_s});
            else begin
               e = exp_q.pop_front();
               if ({oc_s, os_s} !== e) $display("FAIL stall_value: got %h want %h", {oc_s, os_s}, e);
               else n_pass++;
            end
         end
      end
      ir = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      while (exp_q.size() > 0 && guard < 20) begin
         step();
         guard++;
         if (aout_s) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({oc_s, os_s} !== e) $display("FAIL stall_value: got %h want %h", {oc_s, os_s}, e);
            else n_pass++;
         end
      end
      n_checks++; if (exp_q.size() != 0) $display("FAIL stall_drain: left %0d want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_full;
      logic [32:0] e;
      int n_acc = 0;
      ir = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, $urandom, $urandom, $urandom_range(1, 0) == 1);
         step();
         if (ain_s) n_acc++;
      end
      n_checks++; if (n_acc != 6) $display("FAIL full_accepted: got %0d want 6", n_acc); else n_pass++;
      n_checks++; if (or_s !== 1'b0) $display("FAIL full_ready: got %b want 0", or_s); else n_pass++;
      n_checks++; if (ov_s !== 1'b1) $display("FAIL full_valid: got %b want 1", ov_s); else n_pass++;
      ir = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (!aout_s || exp_q.size() == 0) $display("FAIL full_release%0d: o_valid %b want 1", i, ov_s);
         else begin
            e = exp_q.pop_front();
            if ({oc_s, os_s} !== e) $display("FAIL full_value%0d: got %h want %h", i, {oc_s, os_s}, e);
            else n_pass++;
         end
      end
      step();
      n_checks++; if (ov_s !== 1'b0) $display("FAIL full_empty: o_valid %b want 0", ov_s); else n_pass++;
   endtask

   task automatic test_reset_midflight;
      logic [32:0] e;
      int cnt;
      ir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, $urandom, $urandom, $urandom_range(1, 0) == 1);
         step();
      end
      rst = 1'b1;
      drive(1'b1, $urandom, $urandom, 1'b1);
      step();
      rst = 1'b0;
      drive(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
      step();
      n_checks++; if (ov_s !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", ov_s); else n_pass++;
      n_checks++; if (os_s !== 32'd0) $display("FAIL rstmid_sum: got %h want 0", os_s); else n_pass++;
      n_checks++; if (oc_s !== 1'b0) $display("FAIL rstmid_cout: got %b want 0", oc_s); else n_pass++;
      n_checks++; if (or_s !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", or_s); else n_pass++;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!ov_s && cnt < 20);
      n_checks++; if (cnt != 6) $display("FAIL rstmid_latency: got %0d want 6", cnt); else n_pass++;
      n_checks++;
      if (exp_q.size() != 1) $display("FAIL rstmid_queue: got %0d want 1", exp_q.size());
      else begin
         e = exp_q.pop_front();
         if ({oc_s, os_s} !== e) $display("FAIL rstmid_value: got %h want %h", {oc_s, os_s}, e);
         else n_pass++;
      end
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++;
         if (ov_s !== 1'b0) $display("FAIL rstmid_leak: cycle %0d o_valid %b want 0", i, ov_s);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; ir = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      test_reset();
      test_directed();
      test_back_to_back();
      test_random_stall();
      test_full();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
